// File: rtl/dmem_pkg.sv
// Shared types and helpers for the line-based data memory responder.
//   state_e        : responder FSM states
//   WORDS_PER_LINE : 32-bit beats per 128-bit line
//   LINE_BITS      : width of one stored line
//   OFFSET_BITS    : byte-offset bits dropped from the request address
//   word_sel()     : picks beat N of a line, beat 0 being the most significant word
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RBURST  = 2'd2,
    WCOMMIT = 2'd3
  } state_e;

  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_BITS      = 128;
  localparam int OFFSET_BITS    = 4;

  function automatic logic [31:0] word_sel(input logic [LINE_BITS-1:0] line,
                                           input logic [1:0]           beat);
    logic [31:0] w;
    case (beat)
      2'd0:    w = line[127:96];
      2'd1:    w = line[95:64];
      2'd2:    w = line[63:32];
      default: w = line[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Line storage: LINES entries of 128 bits, no reset (contents survive RST).
//   clk_i    : clock
//   we_i     : write enable, line written on posedge
//   widx_i   : write line index
//   wdata_i  : write line data
//   ridx_i   : read line index (asynchronous read)
//   rdata_o  : read line data
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int LINES = 2**IDX_W
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     widx_i,
  input  logic [LINE_BITS-1:0] wdata_i,
  input  logic [IDX_W-1:0]     ridx_i,
  output logic [LINE_BITS-1:0] rdata_o
);

  logic [LINE_BITS-1:0] mem_q [LINES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/dmem_line_responder.sv
// Memory-side responder for cache line fills and write-backs.
// Accepts one line request at a time, waits LATENCY cycles, then either
// streams the line as four 32-bit beats or commits a full 128-bit line.
//   CLK, RST            : clock, synchronous active-high reset
//   REQ_VALID/REQ_READY : request handshake (ready only when idle)
//   REQ_WE              : 1 = line write, 0 = line read
//   REQ_ADDR            : byte address, [3:0] ignored
//   REQ_WDATA           : write line, word0 in [127:96]
//   RESP_VALID/READY    : read beat handshake
//   RESP_DATA/RESP_LAST : read beat data, last-beat marker
//   WR_DONE             : one-cycle pulse when a write line is committed
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request
// WAIT    | access latency countdown
// RBURST  | line latched; present beats 0..3 under RESP handshake
// WCOMMIT | write line into storage on the leaving edge, pulse WR_DONE
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 3,
  parameter int LINES   = 2**(ADDR_W-4)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [127:0]      REQ_WDATA,
  output logic              RESP_VALID,
  input  logic              RESP_READY,
  output logic [31:0]       RESP_DATA,
  output logic              RESP_LAST,
  output logic              WR_DONE
);

  localparam int                IDX_W     = ADDR_W - OFFSET_BITS;
  localparam int                BEAT_W    = $clog2(WORDS_PER_LINE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [3:0]        CNT_LOAD  = 4'(LATENCY - 1);

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [BEAT_W-1:0]    beat_d;
  logic                 we_q;
  logic [IDX_W-1:0]     idx_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic [LINE_BITS-1:0] line_q;
  logic                 ready_q;
  logic                 rvalid_q;
  logic [31:0]          rdata_q;
  logic                 rlast_q;
  logic                 wr_done_q;
  logic [LINE_BITS-1:0] rd_line;
  logic                 commit;
  logic                 addr_offset_unused;

  assign addr_offset_unused = ^REQ_ADDR[OFFSET_BITS-1:0];
  assign beat_d             = beat_q + 1'b1;

  // RST on the commit edge wins: the write is dropped.
  assign commit = (state_q == WCOMMIT) && !RST;

  dmem_line_array #(
    .IDX_W (IDX_W),
    .LINES (LINES)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (commit),
    .widx_i  (idx_q),
    .wdata_i (wdata_q),
    .ridx_i  (idx_q),
    .rdata_o (rd_line)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      beat_q    <= '0;
      ready_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (REQ_VALID && ready_q) begin
            we_q    <= REQ_WE;
            idx_q   <= REQ_ADDR[ADDR_W-1:OFFSET_BITS];
            wdata_q <= REQ_WDATA;
            cnt_q   <= CNT_LOAD;
            ready_q <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            // Snapshot the line here so a read sees any earlier committed write.
            beat_q  <= '0;
            line_q  <= rd_line;
            state_q <= we_q ? WCOMMIT : RBURST;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RBURST: begin
          // First RBURST cycle loads the output registers with beat 0.
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= word_sel(line_q, beat_q);
            rlast_q  <= (beat_q == LAST_BEAT);
          end else if (RESP_READY) begin
            if (beat_q == LAST_BEAT) begin
              rvalid_q <= 1'b0;
              rdata_q  <= '0;
              rlast_q  <= 1'b0;
              ready_q  <= 1'b1;
              state_q  <= IDLE;
            end else begin
              beat_q  <= beat_d;
              rdata_q <= word_sel(line_q, beat_d);
              rlast_q <= (beat_d == LAST_BEAT);
            end
          end
        end
        WCOMMIT: begin
          wr_done_q <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ_READY  = ready_q;
  assign RESP_VALID = rvalid_q;
  assign RESP_DATA  = rdata_q;
  assign RESP_LAST  = rlast_q;
  assign WR_DONE    = wr_done_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
module tb_dmem_line_responder;

  localparam int LAT0 = 3;
  localparam int LAT1 = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [1:0][11:0]    req_addr;
  logic [1:0][127:0]   req_wdata;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready;
  logic [1:0][31:0]    resp_data;
  logic [1:0]          resp_last;
  logic [1:0]          wr_done;

  int tests = 0;
  int fails = 0;

  // Reference memory image: one per instance, plus which lines hold known data.
  logic [127:0] mem_m [2][256];
  bit           known [2][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_line_responder #(
      .ADDR_W  (12),
      .LATENCY ((g == 0) ? LAT0 : LAT1)
    ) dut (
      .CLK        (clk),
      .RST        (rst),
      .REQ_VALID  (req_valid[g]),
      .REQ_READY  (req_ready[g]),
      .REQ_WE     (req_we[g]),
      .REQ_ADDR   (req_addr[g]),
      .REQ_WDATA  (req_wdata[g]),
      .RESP_VALID (resp_valid[g]),
      .RESP_READY (resp_ready[g]),
      .RESP_DATA  (resp_data[g]),
      .RESP_LAST  (resp_last[g]),
      .WR_DONE    (wr_done[g])
    );
  end

  function automatic int lat(input int u);
    return (u == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] wsel(input logic [127:0] l, input int b);
    return l[127-32*b -: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input int u, input logic we, input logic [11:0] a,
                       input logic [127:0] d, input bit hold);
    int guard = 0;
    while (req_ready[u] !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    chk("ready_before_req", req_ready[u], 1'b1);
    req_we[u]    = we;
    req_addr[u]  = a;
    req_wdata[u] = d;
    req_valid[u] = 1'b1;
    step();
    if (!hold) begin
      // Scramble the bus so only the latched request can produce correct results.
      req_valid[u] = 1'b0;
      req_we[u]    = 1'($urandom);
      req_addr[u]  = 12'($urandom);
      req_wdata[u] = {$urandom, $urandom, $urandom, $urandom};
    end
    chk("ready_after_accept", req_ready[u], 1'b0);
  endtask

  task automatic finish_write(input int u, input logic [11:0] a, input logic [127:0] d);
    int l = lat(u);
    for (int k = 1; k <= l + 1; k++) begin
      step();
      chk("wr_done_timing", wr_done[u], (k == l + 1));
      chk("ready_during_write", req_ready[u], (k == l + 1));
      chk("no_resp_on_write", resp_valid[u], 1'b0);
    end
    mem_m[u][a[11:4]] = d;
    known[u][a[11:4]] = 1'b1;
    step();
    chk("wr_done_width", wr_done[u], 1'b0);
  endtask

  task automatic finish_read(input int u, input logic [127:0] line, input int st [4]);
    int l = lat(u);
    int beat = 0;
    int stall = 0;
    int cyc = 0;
    int total = 4 + st[0] + st[1] + st[2] + st[3];
    for (int k = 1; k <= l; k++) begin
      step();
      chk("no_beat_in_wait", resp_valid[u], 1'b0);
    end
    step();
    while (beat < 4 && cyc < 64) begin
      chk("beat_valid", resp_valid[u], 1'b1);
      chk("beat_data", resp_data[u], wsel(line, beat));
      chk("beat_last", resp_last[u], (beat == 3));
      chk("ready_busy", req_ready[u], 1'b0);
      if (stall < st[beat]) begin
        resp_ready[u] = 1'b0;
        stall++;
      end else begin
        resp_ready[u] = 1'b1;
      end
      step();
      cyc++;
      if (resp_ready[u]) begin
        beat++;
        stall = 0;
      end
    end
    resp_ready[u] = 1'b1;
    chk("burst_complete", beat, 4);
    chk("burst_cycles", cyc, total);
    chk("valid_drop", resp_valid[u], 1'b0);
    chk("last_drop", resp_last[u], 1'b0);
    chk("ready_return", req_ready[u], 1'b1);
  endtask

  typedef struct {
    int           u;
    bit           we;
    logic [11:0]  addr;
    logic [127:0] data;
    int           s1;
    int           s2;
  } vec_t;

  localparam logic [127:0] L_A   = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] L_Z   = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] L_TOP = 128'hCAFEF00D_01234567_89ABCDEF_76543210;
  localparam logic [127:0] L_MID = 128'h0BADF00D_FEEDFACE_13579BDF_2468ACE0;
  localparam logic [127:0] L_DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  initial begin
    vec_t tv [9];
    int   st [4];

    rst        = 1'b1;
    req_valid  = 2'b11;
    req_we     = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 2'b11;

    for (int c = 0; c < 2; c++) begin
      step();
      for (int u = 0; u < 2; u++) begin
        chk("rst_ready", req_ready[u], 1'b1);
        chk("rst_valid", resp_valid[u], 1'b0);
        chk("rst_data", resp_data[u], 32'h0);
        chk("rst_last", resp_last[u], 1'b0);
        chk("rst_wr_done", wr_done[u], 1'b0);
      end
    end
    req_valid = 2'b00;
    rst       = 1'b0;
    step();
    for (int u = 0; u < 2; u++) chk("no_accept_in_rst", req_ready[u], 1'b1);

    tv[0] = '{0, 1'b1, 12'h0A0, L_A,   0, 0};
    tv[1] = '{0, 1'b0, 12'h0A8, L_A,   0, 0};
    tv[2] = '{0, 1'b0, 12'h0A8, L_A,   3, 3};
    tv[3] = '{1, 1'b1, 12'h000, L_Z,   0, 0};
    tv[4] = '{1, 1'b1, 12'hFF0, L_TOP, 0, 0};
    tv[5] = '{1, 1'b0, 12'hFFC, L_TOP, 0, 0};
    tv[6] = '{1, 1'b0, 12'h000, L_Z,   1, 0};
    tv[7] = '{0, 1'b1, 12'h5A3, L_MID, 0, 0};
    tv[8] = '{0, 1'b0, 12'h5AF, L_MID, 2, 1};
    for (int i = 0; i < 9; i++) begin
      issue(tv[i].u, tv[i].we, tv[i].addr, tv[i].we ? tv[i].data : 128'h0, 1'b0);
      if (tv[i].we) begin
        finish_write(tv[i].u, tv[i].addr, tv[i].data);
      end else begin
        st = '{0, tv[i].s1, tv[i].s2, 0};
        finish_read(tv[i].u, tv[i].data, st);
      end
    end

    // Busy rejection: a held request is taken only once the burst has ended.
    st = '{0, 0, 0, 0};
    issue(0, 1'b0, 12'h0A0, 128'h0, 1'b1);
    finish_read(0, L_A, st);
    step();
    chk("held_req_accepted", req_ready[0], 1'b0);
    req_valid[0] = 1'b0;
    finish_read(0, L_A, st);

    // Reset while a write is waiting: storage must keep the old line.
    issue(0, 1'b1, 12'h0A0, L_DEAD, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_wait_ready", req_ready[0], 1'b1);
    chk("rst_wait_done", wr_done[0], 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("aborted_no_done", wr_done[0], 1'b0);
    end
    issue(0, 1'b0, 12'h0A4, 128'h0, 1'b0);
    finish_read(0, mem_m[0][8'h0A], st);

    // Reset on the commit edge (LATENCY=1 instance).
    issue(1, 1'b1, 12'hFF0, L_DEAD, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_commit_done", wr_done[1], 1'b0);
    chk("rst_commit_ready", req_ready[1], 1'b1);
    step();
    chk("rst_commit_done_late", wr_done[1], 1'b0);
    issue(1, 1'b0, 12'hFF8, 128'h0, 1'b0);
    finish_read(1, L_TOP, st);

    // Reset while beat 2 of a read is on the bus.
    issue(0, 1'b0, 12'h0A4, 128'h0, 1'b0);
    resp_ready[0] = 1'b1;
    for (int k = 0; k < LAT0 + 1; k++) step();
    chk("mid_beat0", resp_data[0], wsel(L_A, 0));
    step();
    chk("mid_beat1", resp_data[0], wsel(L_A, 1));
    step();
    chk("mid_beat2", resp_data[0], wsel(L_A, 2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", resp_valid[0], 1'b0);
    chk("mid_rst_data", resp_data[0], 32'h0);
    chk("mid_rst_last", resp_last[0], 1'b0);
    chk("mid_rst_ready", req_ready[0], 1'b1);

    // Random traffic against the memory-image model.
    for (int n = 0; n < 60; n++) begin
      int           u;
      logic [7:0]   idx;
      logic [11:0]  a;
      logic [127:0] d;
      bit           we;
      u   = $urandom_range(0, 1);
      idx = 8'($urandom_range(0, 5) * 37);
      a   = {idx, 4'($urandom)};
      we  = !known[u][idx] || ($urandom_range(0, 2) == 0);
      d   = {$urandom, $urandom, $urandom, $urandom};
      if (we) begin
        issue(u, 1'b1, a, d, 1'b0);
        finish_write(u, a, d);
      end else begin
        for (int b = 0; b < 4; b++) st[b] = $urandom_range(0, 2);
        issue(u, 1'b0, a, 128'h0, 1'b0);
        finish_read(u, mem_m[u][idx], st);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
